// File: rtl/input_reader.sv
// Buffer reader: splits a host buffer into boundary-aligned read requests, bounds the
// bytes in flight, and forwards the returned beats as one framed output stream.
module input_reader #(
   parameter int DATA_BYTES         = 64,
   parameter int MAX_REQ_BYTES      = 4096,
   parameter int MAX_INFLIGHT_BYTES = 16384,
   parameter int VADDR_BITS         = 64,
   localparam int LEN_BITS          = 28
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      buf_valid,
   output logic                      buf_ready,
   input  logic [VADDR_BITS-1:0]     buf_vaddr,
   input  logic [LEN_BITS-1:0]       buf_size,
   output logic                      rd_req_valid,
   input  logic                      rd_req_ready,
   output logic [VADDR_BITS-1:0]     rd_req_vaddr,
   output logic [LEN_BITS-1:0]       rd_req_len,
   input  logic [DATA_BYTES*8-1:0]   rd_tdata,
   input  logic                      rd_tvalid,
   output logic                      rd_tready,
   output logic [DATA_BYTES*8-1:0]   out_tdata,
   output logic [DATA_BYTES-1:0]     out_tkeep,
   output logic                      out_tlast,
   output logic                      out_tvalid,
   input  logic                      out_tready,
   output logic                      done,
   output logic                      err_align
);

   localparam int IF_BITS  = $clog2(MAX_INFLIGHT_BYTES) + 1;
   localparam int OFF_BITS = $clog2(MAX_REQ_BYTES);
   localparam logic [VADDR_BITS-1:0] ADDR_MASK = VADDR_BITS'(DATA_BYTES - 1);
   localparam logic [LEN_BITS-1:0]   SIZE_MASK = LEN_BITS'(DATA_BYTES - 1);
   localparam logic [LEN_BITS-1:0]   BEAT_LEN  = LEN_BITS'(DATA_BYTES);
   localparam logic [IF_BITS-1:0]    BEAT_IF   = IF_BITS'(DATA_BYTES);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                 state;
   logic [VADDR_BITS-1:0]  addr;
   logic [LEN_BITS-1:0]    size;
   logic [LEN_BITS-1:0]    remaining;
   logic [LEN_BITS-1:0]    received;
   logic [IF_BITS-1:0]     inflight;
   logic                   done_q;

   logic [OFF_BITS:0]      room;
   logic [LEN_BITS-1:0]    room_len;
   logic [IF_BITS:0]       inflight_need;
   logic                   desc_hs;
   logic                   misaligned;
   logic                   req_hs;
   logic                   beat;
   logic                   last_hs;

   // Bytes left before the next MAX_REQ_BYTES boundary; a request never crosses it.
   assign room          = (OFF_BITS+1)'(MAX_REQ_BYTES) - {1'b0, addr[OFF_BITS-1:0]};
   assign room_len      = LEN_BITS'(room);
   assign rd_req_vaddr  = addr;
   assign rd_req_len    = (remaining < room_len) ? remaining : room_len;
   assign inflight_need = {1'b0, inflight} + (IF_BITS+1)'(rd_req_len);
   assign rd_req_valid  = (state == ISSUE) && (inflight_need <= (IF_BITS+1)'(MAX_INFLIGHT_BYTES));

   assign desc_hs    = buf_valid && buf_ready;
   assign misaligned = ((buf_vaddr & ADDR_MASK) != '0) || ((buf_size & SIZE_MASK) != '0);
   assign req_hs     = rd_req_valid && rd_req_ready;

   // Accept a host beat only when bytes are owed and the output register can take it.
   assign rd_tready = (state != IDLE) && (inflight != '0) && (!out_tvalid || out_tready);
   assign beat      = rd_tvalid && rd_tready;
   assign last_hs   = (state == DRAIN) && out_tvalid && out_tready && out_tlast;
   assign done      = done_q || last_hs;
   assign out_tkeep = '1;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         buf_ready  <= 1'b0;
         addr       <= '0;
         size       <= '0;
         remaining  <= '0;
         received   <= '0;
         inflight   <= '0;
         done_q     <= 1'b0;
         err_align  <= 1'b0;
         out_tvalid <= 1'b0;
         out_tlast  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               buf_ready <= 1'b1;
               if (desc_hs) begin
                  if (misaligned) begin
                     err_align <= 1'b1;
                  end else begin
                     addr      <= buf_vaddr;
                     size      <= buf_size;
                     remaining <= buf_size;
                     received  <= '0;
                     if (buf_size == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        state     <= ISSUE;
                        buf_ready <= 1'b0;
                     end
                  end
               end
            end
            ISSUE: begin
               if (req_hs) begin
                  addr      <= addr + VADDR_BITS'(rd_req_len);
                  remaining <= remaining - rd_req_len;
                  if (remaining == rd_req_len) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_hs) begin
                  state     <= IDLE;
                  buf_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         inflight <= inflight + (req_hs ? IF_BITS'(rd_req_len) : '0) - (beat ? BEAT_IF : '0);

         if (beat) begin
            received   <= received + BEAT_LEN;
            out_tvalid <= 1'b1;
            out_tlast  <= (received + BEAT_LEN == size);
         end else if (out_tready) begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
         end
      end
   end

   // NOTE: payload register carries no reset; out_tvalid alone qualifies it.
   always_ff @(posedge aclk) begin
      if (beat) out_tdata <= rd_tdata;
   end

endmodule

// File: tb/tb_input_reader.sv
// Self-checking bench for input_reader: scoreboarded request split, data order,
// framing, in-flight cap, descriptor corner cases and reset behaviour.
module tb_input_reader;

   localparam int DB    = 64;
   localparam int MAXRQ = 4096;
   localparam int MAXIF = 16384;
   localparam int VB    = 64;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             buf_valid = 1'b0;
   logic             buf_ready;
   logic [VB-1:0]    buf_vaddr = '0;
   logic [27:0]      buf_size = '0;
   logic             rd_req_valid;
   logic             rd_req_ready = 1'b0;
   logic [VB-1:0]    rd_req_vaddr;
   logic [27:0]      rd_req_len;
   logic [DB*8-1:0]  rd_tdata = '0;
   logic             rd_tvalid = 1'b0;
   logic             rd_tready;
   logic [DB*8-1:0]  out_tdata;
   logic [DB-1:0]    out_tkeep;
   logic             out_tlast;
   logic             out_tvalid;
   logic             out_tready = 1'b0;
   logic             done;
   logic             err_align;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [63:0] addr;
      logic [27:0] len;
   } req_t;

   req_t            exp_req[$];
   logic [DB*8-1:0] exp_data[$];
   bit              exp_last[$];
   int              outstanding = 0;

   input_reader #(
      .DATA_BYTES(DB), .MAX_REQ_BYTES(MAXRQ), .MAX_INFLIGHT_BYTES(MAXIF), .VADDR_BITS(VB)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_vaddr(buf_vaddr), .buf_size(buf_size),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_vaddr(rd_req_vaddr), .rd_req_len(rd_req_len),
      .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
      .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
      .out_tvalid(out_tvalid), .out_tready(out_tready),
      .done(done), .err_align(err_align)
   );

   always #5 aclk = ~aclk;

   // Reference split: chop at every MAX_REQ boundary.
   task automatic plan(input logic [63:0] a, input logic [27:0] s);
      longint ad = longint'(a);
      longint rem = longint'(s);
      while (rem > 0) begin
         longint room = MAXRQ - (ad % MAXRQ);
         longint l = (rem < room) ? rem : room;
         exp_req.push_back({64'(ad), 28'(l)});
         ad += l;
         rem -= l;
      end
   endtask

   task automatic send_desc(input logic [63:0] a, input logic [27:0] s);
      int n = 0;
      @(negedge aclk);
      buf_valid = 1'b1;
      buf_vaddr = a;
      buf_size  = s;
      #1;
      while (buf_ready !== 1'b1 && n < 200) begin
         @(negedge aclk);
         #1;
         n++;
      end
      checks++;
      if (buf_ready !== 1'b1) begin
         failures++;
         $display("FAIL desc_accept: buf_ready=%b required 1 within 200 cycles", buf_ready);
      end
      @(posedge aclk);
      #1;
      buf_valid = 1'b0;
   endtask

   task automatic outputs_idle(input string tag);
      checks++;
      if ({buf_ready, rd_req_valid, rd_tready, out_tvalid, out_tlast, done, err_align} !== 7'b0) begin
         failures++;
         $display("FAIL %s: {buf_ready,rd_req_valid,rd_tready,out_tvalid,out_tlast,done,err_align}=%b required 0000000",
                  tag, {buf_ready, rd_req_valid, rd_tready, out_tvalid, out_tlast, done, err_align});
      end
   endtask

   task automatic run_buffer(input logic [63:0] a, input logic [27:0] s, input int req_pct,
                             input int vld_pct, input int rdy_pct, input int stall,
                             input int abort_after, output int reqs_at_stall);
      int   total = int'(s) / DB;
      int   beat_in = 0;
      int   beats_out = 0;
      int   tlasts = 0;
      int   nreq = 0;
      int   cyc = 0;
      bit   finished = 0;
      req_t e;
      logic [DB*8-1:0] d;
      bit   l;
      reqs_at_stall = -1;
      send_desc(a, s);
      while (!finished && cyc < 30000) begin
         @(negedge aclk);
         cyc++;
         rd_req_ready = (int'($urandom_range(99)) < req_pct);
         rd_tvalid    = (outstanding > 0) && (cyc > stall) && (int'($urandom_range(99)) < vld_pct);
         rd_tdata     = {16{$urandom()}};
         out_tready   = (int'($urandom_range(99)) < rdy_pct);
         #1;
         if (cyc == stall) reqs_at_stall = nreq;

         checks++;
         if (rd_tready === 1'b1 && outstanding == 0) begin
            failures++;
            $display("FAIL rd_tready_idle: rd_tready=1 with 0 bytes outstanding, required 0");
         end

         if (out_tvalid === 1'b1 && out_tready) begin
            checks++;
            if (exp_data.size() == 0) begin
               failures++;
               $display("FAIL out_extra: out beat %0d with empty scoreboard", beats_out);
            end else begin
               d = exp_data.pop_front();
               l = exp_last.pop_front();
               if (out_tdata !== d || out_tlast !== l || out_tkeep !== {DB{1'b1}}) begin
                  failures++;
                  $display("FAIL out_beat %0d: data=%h last=%b keep=%h required data=%h last=%b keep=all-ones",
                           beats_out, out_tdata, out_tlast, out_tkeep, d, l);
               end
            end
            checks++;
            if (done !== out_tlast) begin
               failures++;
               $display("FAIL done_on_last: done=%b required %b", done, out_tlast);
            end
            beats_out++;
            if (out_tlast === 1'b1) begin
               tlasts++;
               finished = 1;
            end
            if (abort_after > 0 && beats_out == abort_after) finished = 1;
         end else begin
            checks++;
            if (done !== 1'b0) begin
               failures++;
               $display("FAIL done_spurious: done=%b required 0", done);
            end
         end

         if (rd_tvalid && rd_tready === 1'b1) begin
            exp_data.push_back(rd_tdata);
            exp_last.push_back(beat_in == total - 1);
            beat_in++;
            outstanding -= DB;
         end

         if (rd_req_valid === 1'b1) begin
            checks++;
            if (outstanding + int'(rd_req_len) + ((rd_tvalid && rd_tready) ? DB : 0) > MAXIF) begin
               failures++;
               $display("FAIL inflight_cap: outstanding=%0d len=%0d required sum<=%0d",
                        outstanding, rd_req_len, MAXIF);
            end
            if (rd_req_ready) begin
               checks++;
               if (exp_req.size() == 0) begin
                  failures++;
                  $display("FAIL req_extra: (%h,%0d) not expected", rd_req_vaddr, rd_req_len);
               end else begin
                  e = exp_req.pop_front();
                  if (rd_req_vaddr !== e.addr || rd_req_len !== e.len) begin
                     failures++;
                     $display("FAIL req_fields: (%h,%0d) required (%h,%0d)",
                              rd_req_vaddr, rd_req_len, e.addr, e.len);
                  end
               end
               outstanding += int'(rd_req_len);
               nreq++;
            end
         end
      end

      if (abort_after == 0) begin
         @(posedge aclk);
         #1;
         rd_tvalid = 1'b0;
         rd_req_ready = 1'b0;
         out_tready = 1'b0;
         checks++;
         if (!finished || beats_out != total || tlasts != 1) begin
            failures++;
            $display("FAIL buffer_end: finished=%0d beats=%0d tlasts=%0d required 1/%0d/1",
                     finished, beats_out, tlasts, total);
         end
         checks++;
         if (exp_req.size() != 0 || exp_data.size() != 0 || outstanding != 0) begin
            failures++;
            $display("FAIL leftovers: reqs=%0d data=%0d outstanding=%0d required 0/0/0",
                     exp_req.size(), exp_data.size(), outstanding);
         end
         checks++;
         if (buf_ready !== 1'b1) begin
            failures++;
            $display("FAIL back_to_idle: buf_ready=%b required 1", buf_ready);
         end
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      rd_tvalid = 1'b1;
      out_tready = 1'b1;
      repeat (3) @(negedge aclk);
      #1;
      outputs_idle("reset_outputs");
      @(negedge aclk);
      aresetn = 1'b1;
      rd_tvalid = 1'b0;
      out_tready = 1'b0;
      @(posedge aclk);
      #1;
      checks++;
      if (buf_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: buf_ready=%b required 1", buf_ready);
      end
   endtask

   task automatic test_single();
      int r;
      exp_req.push_back({64'h1000, 28'd256});
      run_buffer(64'h1000, 28'd256, 100, 100, 100, 0, 0, r);
   endtask

   task automatic test_split();
      int r;
      exp_req.push_back({64'h1F00, 28'h100});
      exp_req.push_back({64'h2000, 28'h200});
      run_buffer(64'h1F00, 28'h300, 70, 70, 80, 0, 0, r);
   endtask

   task automatic test_zero_and_align();
      send_desc(64'h3000, 28'd0);
      checks++;
      if (done !== 1'b1 || rd_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL zero_done: done=%b rd_req_valid=%b required 1/0", done, rd_req_valid);
      end
      @(posedge aclk);
      #1;
      checks++;
      if (done !== 1'b0 || buf_ready !== 1'b1 || out_tvalid !== 1'b0 || err_align !== 1'b0) begin
         failures++;
         $display("FAIL zero_after: done=%b buf_ready=%b out_tvalid=%b err_align=%b required 0/1/0/0",
                  done, buf_ready, out_tvalid, err_align);
      end
      for (int k = 0; k < 2; k++) begin
         if (k == 0) send_desc(64'h1004, 28'd64);
         else        send_desc(64'h2000, 28'd100);
         for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            #1;
            checks++;
            if (rd_req_valid !== 1'b0 || done !== 1'b0 || err_align !== 1'b1 || buf_ready !== 1'b1) begin
               failures++;
               $display("FAIL misalign_%0d: rd_req_valid=%b done=%b err_align=%b buf_ready=%b required 0/0/1/1",
                        k, rd_req_valid, done, err_align, buf_ready);
            end
         end
      end
   endtask

   task automatic test_inflight_cap();
      int r;
      plan(64'h10000, 28'd65536);
      run_buffer(64'h10000, 28'd65536, 100, 100, 100, 40, 0, r);
      checks++;
      if (r != 4) begin
         failures++;
         $display("FAIL cap_requests: %0d requests before data returned, required 4", r);
      end
      checks++;
      if (err_align !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: err_align=%b required 1", err_align);
      end
   endtask

   task automatic test_backpressure();
      int r;
      plan(64'h40000, 28'd8192);
      run_buffer(64'h40000, 28'd8192, 60, 50, 50, 0, 0, r);
   endtask

   task automatic test_reset_mid();
      int r;
      plan(64'h5000, 28'd256);
      run_buffer(64'h5000, 28'd256, 100, 100, 100, 0, 1, r);
      @(negedge aclk);
      aresetn = 1'b0;
      rd_tvalid = 1'b1;
      out_tready = 1'b1;
      #1;
      outputs_idle("reset_mid_drain");
      exp_req.delete();
      exp_data.delete();
      exp_last.delete();
      outstanding = 0;
      @(negedge aclk);
      aresetn = 1'b1;
      rd_tvalid = 1'b0;
      rd_req_ready = 1'b0;
      out_tready = 1'b0;
      @(posedge aclk);
      #1;
      checks++;
      if (buf_ready !== 1'b1 || err_align !== 1'b0) begin
         failures++;
         $display("FAIL after_mid_reset: buf_ready=%b err_align=%b required 1/0", buf_ready, err_align);
      end
      plan(64'h6000, 28'd128);
      run_buffer(64'h6000, 28'd128, 100, 100, 100, 0, 0, r);
   endtask

   initial begin
      test_reset();
      test_single();
      test_split();
      test_zero_and_align();
      test_inflight_cap();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
